// File: rtl/sos_pkg.sv
// Shared types and defaults for the SOS beacon sequencer and its timer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sos_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_GAP1 = 3'd2,
    ST_O    = 3'd3,
    ST_GAP2 = 3'd4,
    ST_S2   = 3'd5,
    ST_FGAP = 3'd6
  } state_e;

  localparam logic [15:0] T1MS_DEF          = 16'd49_999;
  localparam logic [9:0]  LETTER_GAP_MS_DEF = 10'd150;
  localparam logic [9:0]  FRAME_GAP_MS_DEF  = 10'd1000;

  // Buzzer lines are active low, so silence is a 1.
  localparam logic BUZZ_OFF = 1'b1;

  function automatic logic is_gap(state_e s);
    return (s == ST_GAP1) || (s == ST_GAP2) || (s == ST_FGAP);
  endfunction

endpackage

// File: rtl/sos_sequencer_if.sv
// Bundle of enable, letter-generator handshakes, buzzer lines and frame status.
// Latency: n/a (wiring only).
// Backpressure: start levels are held until the matching done pulse.
interface sos_sequencer_if;
  logic       enable;
  logic       s_done_sig;
  logic       o_done_sig;
  logic       s_pin_out;
  logic       o_pin_out;
  logic       s_start_sig;
  logic       o_start_sig;
  logic       pin_out;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_cnt;

  // Sequencer side.
  modport slave (
    input  enable, s_done_sig, o_done_sig, s_pin_out, o_pin_out,
    output s_start_sig, o_start_sig, pin_out, busy, frame_done, frame_cnt
  );

  // Board / generator side.
  modport master (
    output enable, s_done_sig, o_done_sig, s_pin_out, o_pin_out,
    input  s_start_sig, o_start_sig, pin_out, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/ms_timer.sv
// Millisecond interval timer: tick prescaler plus ms counter with exact-match expiry.
// Latency: expired is combinational on the last cycle of a limit x (T1MS+1) window.
// Backpressure: none; counts only while run is high, clear wins over run.
module ms_timer
  import sos_pkg::*;
#(
  parameter logic [15:0] T1MS = T1MS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       run,
  input  logic [9:0] limit,
  output logic       expired
);

  logic [15:0] tick_q, tick_d;
  logic [9:0]  ms_q, ms_d;
  logic        tick_wrap;

  assign tick_wrap = (tick_q == T1MS);

  // Expires on the final cycle of the window so the owner leaves after exactly limit ms.
  assign expired = run && tick_wrap && ((ms_q + 10'd1) == limit);

  // Advance the prescaler every running cycle and the ms count at each prescaler wrap.
  always_comb begin
    tick_d = tick_q;
    ms_d   = ms_q;
    if (clear) begin
      tick_d = '0;
      ms_d   = '0;
    end else if (run) begin
      if (tick_wrap) begin
        tick_d = '0;
        ms_d   = ms_q + 10'd1;
      end else begin
        tick_d = tick_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      ms_q   <= '0;
    end else begin
      tick_q <= tick_d;
      ms_q   <= ms_d;
    end
  end

endmodule

// File: rtl/sos_sequencer.sv
// Orders the S and O letter generators into S-O-S frames with timed letter/frame silences.
// Latency: every output is registered; done sampled at edge k updates state and starts at k+1.
// Backpressure: start levels hold until the active generator's done; enable only sampled at frame boundaries.
module sos_sequencer
  import sos_pkg::*;
#(
  parameter logic [15:0] T1MS          = T1MS_DEF,
  parameter logic [9:0]  LETTER_GAP_MS = LETTER_GAP_MS_DEF,
  parameter logic [9:0]  FRAME_GAP_MS  = FRAME_GAP_MS_DEF
) (
  input logic            clk,
  input logic            rst_n,
  sos_sequencer_if.slave bus
);

  localparam logic LETTER_GAP_ON = (LETTER_GAP_MS != 10'd0);
  localparam logic FRAME_GAP_ON  = (FRAME_GAP_MS != 10'd0);

  state_e     state_q, state_d;
  logic       s_start_q, s_start_d;
  logic       o_start_q, o_start_d;
  logic       pin_out_q, pin_out_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       s_acc, o_acc;
  logic       tmr_clear, tmr_run, tmr_expired;
  logic [9:0] tmr_limit;

  // Only the generator that currently owns the sequence may end its letter.
  assign s_acc = bus.s_done_sig && ((state_q == ST_S1) || (state_q == ST_S2));
  assign o_acc = bus.o_done_sig && (state_q == ST_O);

  // The timer restarts on every state change, so each gap begins from zero.
  assign tmr_run   = is_gap(state_q);
  assign tmr_clear = (state_d != state_q);
  assign tmr_limit = (state_q == ST_FGAP) ? FRAME_GAP_MS : LETTER_GAP_MS;

  ms_timer #(.T1MS(T1MS)) u_ms_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  // Next state: letters advance on their own done, gaps on timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.enable) state_d = ST_S1;
      ST_S1:   if (s_acc) state_d = LETTER_GAP_ON ? ST_GAP1 : ST_O;
      ST_GAP1: if (tmr_expired) state_d = ST_O;
      ST_O:    if (o_acc) state_d = LETTER_GAP_ON ? ST_GAP2 : ST_S2;
      ST_GAP2: if (tmr_expired) state_d = ST_S2;
      ST_S2: begin
        if (s_acc) begin
          if (!bus.enable)  state_d = ST_IDLE;
          else              state_d = FRAME_GAP_ON ? ST_FGAP : ST_S1;
        end
      end
      ST_FGAP: if (tmr_expired) state_d = bus.enable ? ST_S1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode for the registers; S start drops for a cycle after any S done so the
  // generator parks even when S2 chains straight into S1.
  always_comb begin
    s_start_d    = ((state_d == ST_S1) || (state_d == ST_S2)) && !s_acc;
    o_start_d    = (state_d == ST_O);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = s_acc && (state_q == ST_S2);
    frame_cnt_d  = frame_cnt_q + {7'd0, frame_done_d};
    pin_out_d    = BUZZ_OFF;
    case (state_q)
      ST_S1, ST_S2: pin_out_d = bus.s_pin_out;
      ST_O:         pin_out_d = bus.o_pin_out;
      default:      pin_out_d = BUZZ_OFF;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_start_q    <= 1'b0;
      o_start_q    <= 1'b0;
      pin_out_q    <= BUZZ_OFF;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      s_start_q    <= s_start_d;
      o_start_q    <= o_start_d;
      pin_out_q    <= pin_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.s_start_sig = s_start_q;
  assign bus.o_start_sig = o_start_q;
  assign bus.pin_out     = pin_out_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sos_sequencer.sv
// Bench for sos_sequencer: two instances (timed gaps, zero gaps) against a phase/countdown model.
// Latency: model predicts registered outputs one edge after sampled inputs.
// Backpressure: generator models hold done until their start has been high D cycles.
module tb_sos_sequencer;

  localparam int REC = 200;
  localparam int LG_A = 2 * 10;  // letter gap cycles for instance A
  localparam int FG_A = 5 * 10;  // frame gap cycles for instance A

  localparam logic [2:0] M_IDLE = 3'd0, M_S1 = 3'd1, M_G1 = 3'd2, M_O = 3'd3,
                         M_G2 = 3'd4, M_S2 = 3'd5, M_FG = 3'd6;

  typedef struct packed {
    logic [2:0]  ph;
    logic [31:0] left;
    logic        ss, os, pin, busy, fd;
    logic [7:0]  cnt;
  } mdl_t;

  logic clk, rst_n;
  sos_sequencer_if ifa ();
  sos_sequencer_if ifb ();

  sos_sequencer #(.T1MS(16'd9), .LETTER_GAP_MS(10'd2), .FRAME_GAP_MS(10'd5)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  sos_sequencer #(.T1MS(16'd9), .LETTER_GAP_MS(10'd0), .FRAME_GAP_MS(10'd0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Generator-model controls, indexed 0=A.s 1=A.o 2=B.s 3=B.o.
  int   dfix[4];
  int   dmax[4];
  bit   drand[4];
  logic pfix[4];
  int   inj_at[4];
  bit   pin_rand, spur_rand;

  mdl_t ma, mb;
  int   r[5][REC];  // 0 s_start, 1 o_start, 2 frame_done, 3 busy, 4 pin_out
  int   r_cnt[REC];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic mdl_t mreset();
    mdl_t m;
    m = '0;
    m.ph = M_IDLE;
    m.pin = 1'b1;
    return m;
  endfunction

  // One clock of the beacon's rules: phases, countdown gaps, frame counting.
  function automatic mdl_t mstep(mdl_t m, logic en, logic sd, logic od, logic sp, logic op,
                                 int lg, int fg);
    mdl_t n;
    logic took_s;
    n = m;
    n.fd = 1'b0;
    took_s = 1'b0;
    n.pin = (m.ph == M_S1 || m.ph == M_S2) ? sp : (m.ph == M_O) ? op : 1'b1;
    case (m.ph)
      M_IDLE: if (en) n.ph = M_S1;
      M_S1: if (sd) begin
        took_s = 1'b1;
        if (lg == 0) n.ph = M_O;
        else begin n.ph = M_G1; n.left = lg; end
      end
      M_G1: begin n.left = m.left - 1; if (n.left == 0) n.ph = M_O; end
      M_O: if (od) begin
        if (lg == 0) n.ph = M_S2;
        else begin n.ph = M_G2; n.left = lg; end
      end
      M_G2: begin n.left = m.left - 1; if (n.left == 0) n.ph = M_S2; end
      M_S2: if (sd) begin
        took_s = 1'b1;
        n.fd = 1'b1;
        n.cnt = m.cnt + 8'd1;
        if (!en) n.ph = M_IDLE;
        else if (fg == 0) n.ph = M_S1;
        else begin n.ph = M_FG; n.left = fg; end
      end
      M_FG: begin
        n.left = m.left - 1;
        if (n.left == 0) n.ph = en ? M_S1 : M_IDLE;
      end
      default: n.ph = M_IDLE;
    endcase
    n.ss = (n.ph == M_S1 || n.ph == M_S2) && !took_s;
    n.os = (n.ph == M_O);
    n.busy = (n.ph != M_IDLE);
    return n;
  endfunction

  task automatic cmp(input mdl_t e, input string who, input logic ss, input logic os,
                     input logic pin, input logic busy, input logic fd, input logic [7:0] cnt);
    chk({who, ".s_start_sig"}, int'(ss), int'(e.ss));
    chk({who, ".o_start_sig"}, int'(os), int'(e.os));
    chk({who, ".pin_out"}, int'(pin), int'(e.pin));
    chk({who, ".busy"}, int'(busy), int'(e.busy));
    chk({who, ".frame_done"}, int'(fd), int'(e.fd));
    chk({who, ".frame_cnt"}, int'(cnt), int'(e.cnt));
    chk({who, ".start_overlap"}, int'(ss & os), 0);
  endtask

  // Model step on each edge, compared against both instances away from the edge.
  initial begin
    ma = mreset();
    mb = mreset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ma = mreset();
        mb = mreset();
      end else begin
        ma = mstep(ma, ifa.enable, ifa.s_done_sig, ifa.o_done_sig, ifa.s_pin_out,
                   ifa.o_pin_out, LG_A, FG_A);
        mb = mstep(mb, ifb.enable, ifb.s_done_sig, ifb.o_done_sig, ifb.s_pin_out,
                   ifb.o_pin_out, 0, 0);
      end
      #3;
      if (!rst_n) begin
        ma = mreset();
        mb = mreset();
      end
      cmp(ma, "A", ifa.s_start_sig, ifa.o_start_sig, ifa.pin_out, ifa.busy,
          ifa.frame_done, ifa.frame_cnt);
      cmp(mb, "B", ifb.s_start_sig, ifb.o_start_sig, ifb.pin_out, ifb.busy,
          ifb.frame_done, ifb.frame_cnt);
    end
  end

  // Letter generators: done pulses D cycles after start is first seen, plus injected noise.
  initial begin
    int   age[4];
    int   dl[4];
    bit   was[4];
    logic gd[4];
    logic st;
    ifa.s_done_sig = 1'b0; ifa.o_done_sig = 1'b0; ifa.s_pin_out = 1'b1; ifa.o_pin_out = 1'b1;
    ifb.s_done_sig = 1'b0; ifb.o_done_sig = 1'b0; ifb.s_pin_out = 1'b1; ifb.o_pin_out = 1'b1;
    for (int g = 0; g < 4; g++) begin age[g] = 0; dl[g] = 0; was[g] = 1'b0; gd[g] = 1'b0; end
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
        st = (g == 0) ? ifa.s_start_sig : (g == 1) ? ifa.o_start_sig :
             (g == 2) ? ifb.s_start_sig : ifb.o_start_sig;
        gd[g] = 1'b0;
        if (st) begin
          if (!was[g]) begin
            age[g] = 0;
            dl[g] = drand[g] ? int'($urandom_range(0, dmax[g])) : dfix[g];
          end else begin
            age[g]++;
          end
          if (age[g] == dl[g]) gd[g] = 1'b1;
        end
        was[g] = st;
        if (spur_rand && $urandom_range(0, 63) == 0) gd[g] = 1'b1;
        if (cyc == inj_at[g]) gd[g] = 1'b1;
      end
      ifa.s_done_sig = gd[0]; ifa.o_done_sig = gd[1];
      ifb.s_done_sig = gd[2]; ifb.o_done_sig = gd[3];
      if (pin_rand) begin
        ifa.s_pin_out = ($urandom_range(0, 1) == 1); ifa.o_pin_out = ($urandom_range(0, 1) == 1);
        ifb.s_pin_out = ($urandom_range(0, 1) == 1); ifb.o_pin_out = ($urandom_range(0, 1) == 1);
      end else begin
        ifa.s_pin_out = pfix[0]; ifa.o_pin_out = pfix[1];
        ifb.s_pin_out = pfix[2]; ifb.o_pin_out = pfix[3];
      end
    end
  end

  task automatic record(input int which, input bit drop_en);
    for (int i = 0; i < REC; i++) begin
      tick();
      if (which == 0) begin
        r[0][i] = int'(ifa.s_start_sig); r[1][i] = int'(ifa.o_start_sig);
        r[2][i] = int'(ifa.frame_done);  r[3][i] = int'(ifa.busy);
        r[4][i] = int'(ifa.pin_out);     r_cnt[i] = int'(ifa.frame_cnt);
      end else begin
        r[0][i] = int'(ifb.s_start_sig); r[1][i] = int'(ifb.o_start_sig);
        r[2][i] = int'(ifb.frame_done);  r[3][i] = int'(ifb.busy);
        r[4][i] = int'(ifb.pin_out);     r_cnt[i] = int'(ifb.frame_cnt);
      end
      if (i == 0 && drop_en) ifa.enable = 1'b0;
    end
  endtask

  function automatic int first_at(int k, int v, int from);
    for (int i = from; i < REC; i++) if (r[k][i] == v) return i;
    return -1;
  endfunction

  function automatic int run_len(int k, int from);
    int n = 0;
    for (int i = from; i < REC; i++) begin
      if (r[k][i] != 1) break;
      n++;
    end
    return n;
  endfunction

  function automatic int total(int k);
    int n = 0;
    for (int i = 0; i < REC; i++) n += r[k][i];
    return n;
  endfunction

  task automatic single_frame_checks(input string tag);
    chk({tag, ".s1_len"}, run_len(0, 0), 31);
    chk({tag, ".o_rise"}, first_at(1, 1, 0), 51);
    chk({tag, ".o_len"}, run_len(1, 51), 31);
    chk({tag, ".s2_rise"}, first_at(0, 1, 31), 102);
    chk({tag, ".s2_len"}, run_len(0, 102), 31);
    chk({tag, ".fd_at"}, first_at(2, 1, 0), 133);
    chk({tag, ".fd_pulses"}, total(2), 1);
    chk({tag, ".busy_cycles"}, total(3), 133);
    chk({tag, ".pin_idle"}, r[4][0], 1);
    chk({tag, ".pin_s1"}, r[4][5], 0);
    chk({tag, ".pin_gap1"}, r[4][40], 1);
    chk({tag, ".pin_o"}, r[4][60], 0);
    chk({tag, ".pin_gap2"}, r[4][95], 1);
  endtask

  initial begin
    int fdc[3];
    int nfd, srise, tot, wrapped, idle_wait;
    for (int g = 0; g < 4; g++) begin
      dfix[g] = 30; dmax[g] = 0; drand[g] = 1'b0; pfix[g] = 1'b0; inj_at[g] = -1;
    end
    pin_rand = 1'b0; spur_rand = 1'b0;
    rst_n = 1'b0; ifa.enable = 1'b0; ifb.enable = 1'b0;

    // Reset state.
    repeat (3) tick();
    chk("rst.pin_out", int'(ifa.pin_out), 1);
    chk("rst.s_start", int'(ifa.s_start_sig), 0);
    chk("rst.o_start", int'(ifa.o_start_sig), 0);
    chk("rst.busy", int'(ifa.busy), 0);
    chk("rst.frame_cnt", int'(ifa.frame_cnt), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single frame from a one-cycle enable pulse.
    ifa.enable = 1'b1;
    record(0, 1'b1);
    single_frame_checks("single");
    chk("single.cnt", r_cnt[REC-1], 1);

    // Same frame with foreign done pulses in S1 and GAP1: timing must not move.
    inj_at[1] = cyc + 1 + 10;
    inj_at[0] = cyc + 1 + 40;
    ifa.enable = 1'b1;
    record(0, 1'b1);
    single_frame_checks("spur");
    chk("spur.cnt", r_cnt[REC-1], 2);

    // Continuous frames from a fresh reset.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    ifa.enable = 1'b1;
    nfd = 0; srise = -1;
    for (int g = 0; g < 3; g++) fdc[g] = -1;
    for (int i = 0; i < 560; i++) begin
      tick();
      if (ifa.frame_done) begin
        if (nfd < 3) fdc[nfd] = i;
        nfd++;
        chk("cont.frame_cnt", int'(ifa.frame_cnt), nfd);
      end
      if (nfd == 1 && srise < 0 && ifa.s_start_sig) srise = i;
    end
    chk("cont.frames", nfd, 3);
    chk("cont.fd1", fdc[0], 133);
    chk("cont.period2", fdc[1] - fdc[0], 183);
    chk("cont.period3", fdc[2] - fdc[1], 183);
    chk("cont.fgap_end", srise, 183);

    // Mid-letter asynchronous reset.
    chk("pre_rst.s_start", int'(ifa.s_start_sig), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.pin_out", int'(ifa.pin_out), 1);
    chk("rst_mid.s_start", int'(ifa.s_start_sig), 0);
    chk("rst_mid.o_start", int'(ifa.o_start_sig), 0);
    chk("rst_mid.busy", int'(ifa.busy), 0);
    chk("rst_mid.frame_cnt", int'(ifa.frame_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_hold.busy", int'(ifa.busy), 0);
      chk("rst_hold.s_start", int'(ifa.s_start_sig), 0);
    end
    ifa.enable = 1'b0;
    rst_n = 1'b1;
    tick();

    // Zero-gap instance: letters chain on the cycle after each done.
    ifb.enable = 1'b1;
    record(1, 1'b0);
    chk("zero.s1_len", run_len(0, 0), 31);
    chk("zero.o_rise", first_at(1, 1, 0), 31);
    chk("zero.o_len", run_len(1, 31), 31);
    chk("zero.s2_rise", first_at(0, 1, 31), 62);
    chk("zero.fd_at", first_at(2, 1, 0), 93);
    chk("zero.park", r[0][93], 0);
    chk("zero.restart", r[0][94], 1);
    chk("zero.busy", r[3][93], 1);
    chk("zero.cnt", r_cnt[93], 1);

    // Run zero-gap frames quickly until the frame counter wraps.
    tot = total(2);
    drand[2] = 1'b1; drand[3] = 1'b1; dmax[2] = 2; dmax[3] = 2;
    wrapped = 0;
    for (int i = 0; i < 20000 && wrapped == 0; i++) begin
      tick();
      if (ifb.frame_done) begin
        tot++;
        if (ifb.frame_cnt == 8'd0) wrapped = 1;
      end
    end
    chk("wrap.seen", wrapped, 1);
    chk("wrap.frames", tot, 256);

    // Randomized traffic on both instances.
    for (int g = 0; g < 4; g++) drand[g] = 1'b1;
    dmax[0] = 40; dmax[1] = 40; dmax[2] = 5; dmax[3] = 5;
    pin_rand = 1'b1; spur_rand = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      tick();
      if ($urandom_range(0, 49) == 0) ifa.enable = ~ifa.enable;
      if ($urandom_range(0, 29) == 0) ifb.enable = ~ifb.enable;
    end
    spur_rand = 1'b0;
    ifa.enable = 1'b0; ifb.enable = 1'b0;
    idle_wait = 0;
    while ((ifa.busy || ifb.busy) && idle_wait < 3000) begin
      tick();
      idle_wait++;
    end
    chk("drain.a_busy", int'(ifa.busy), 0);
    chk("drain.b_busy", int'(ifb.busy), 0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sos_sequencer.md
# sos_sequencer

Top-level controller for the SOS beacon. It sequences the letter generators `s_module` and `o_module` through their start/done handshakes to emit S, O, S, with timed inter-letter and inter-frame silences. It selects the active generator's active-low buzzer line onto the single `pin_out`. It sits between the board-level enable and the two letter generators; the letter generators keep all Morse timing, and this block owns only ordering and gaps.

## Interface
- `T1MS`, 16'd49_999: clock cycles per 1 ms tick minus one (50 MHz).
- `LETTER_GAP_MS`, 10'd150: silence between letters in ms; 0 means no gap state.
- `FRAME_GAP_MS`, 10'd1000: silence between repeated SOS frames in ms; 0 means no gap state.
- `clk` in 1: system clock; the block uses one clock only.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; high requests continuous SOS frames.
- `s_done_sig` in 1: one-cycle done pulse from `s_module`.
- `o_done_sig` in 1: one-cycle done pulse from `o_module`.
- `s_pin_out` in 1: buzzer line from `s_module`, active low.
- `o_pin_out` in 1: buzzer line from `o_module`, active low.
- `s_start_sig` out 1: level start for `s_module`; held until `s_done_sig`.
- `o_start_sig` out 1: level start for `o_module`; held until `o_done_sig`.
- `pin_out` out 1: registered buzzer output, active low (0 = sounding).
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when a full SOS frame completes.
- `frame_cnt` out 8: count of completed frames; wraps 255→0.

## Operation
- **States:** IDLE, S1, GAP1, O, GAP2, S2, FGAP.
- **IDLE:** if `enable`=1, go to S1.
- **S1:** `s_start_sig`=1. On `s_done_sig`=1, go to GAP1, or directly to O if `LETTER_GAP_MS`=0.
- **GAP1:** lasts exactly `LETTER_GAP_MS`×(`T1MS`+1) cycles, then go to O.
- **O:** `o_start_sig`=1. On `o_done_sig`, go to GAP2, or directly to S2 if `LETTER_GAP_MS`=0.
- **GAP2:** same length as GAP1, then go to S2.
- **S2:** `s_start_sig`=1. On `s_done_sig`:
  - pulse `frame_done` and increment `frame_cnt`;
  - then go to FGAP if `enable`=1 and `FRAME_GAP_MS`≠0;
  - go to S1 if `enable`=1 and `FRAME_GAP_MS`=0;
  - go to IDLE if `enable`=0.
- **FGAP:** lasts `FRAME_GAP_MS`×(`T1MS`+1) cycles. At expiry, go to S1 if `enable`=1, else IDLE.
- **Enable sampling:**
  - `enable` is sampled only in IDLE, at S2 completion, and at FGAP expiry.
  - Dropping `enable` mid-frame always finishes the current frame, because the letter generators cannot be aborted cleanly.
- **Done filtering:** done pulses from the non-active generator, and any done in IDLE or a gap state, are ignored.
- **Start/done handshake:** the start level drops on the cycle after done is sampled. The generator then sees start=0 at its idle step and stays parked.
- **`pin_out` selection (registered):**
  - `s_pin_out` in S1/S2;
  - `o_pin_out` in O;
  - 1 in all other states.
- **Gap timer:**
  - 16-bit tick counter plus 10-bit ms counter.
  - Runs only in gap states.
  - Cleared on every state entry.
  - The expiry compare uses exact equality; there is no overflow path.

## Timing
- **Reset values:** state IDLE, `s_start_sig`=0, `o_start_sig`=0, `pin_out`=1, `busy`=0, `frame_done`=0, `frame_cnt`=0, timers 0.
- **Reset mid-operation:** asynchronous reset is effective immediately from any state. The generators see start=0 and park.
- **Start latency:** `enable` high at edge k gives state S1 and `s_start_sig`=1 from edge k+1.
- **Done to next state:** done sampled at edge k gives the next state and an updated start level at edge k+1.
- **Start overlap:** `s_start_sig` and `o_start_sig` are never high in the same cycle.
- **`pin_out` latency:** one cycle behind the selected input.
- **`frame_done`:** high for exactly the cycle after the S2 done is sampled. `frame_cnt` updates on the same edge.
- **Gap accuracy:** a gap state lasts exactly N×(`T1MS`+1) cycles, ±0.
- **All outputs** are driven from registers; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package `sos_pkg`:**
  - state encoding;
  - default constants `T1MS`, `LETTER_GAP_MS`, `FRAME_GAP_MS`;
  - the active-low buzzer-off value (1).
- **Sub-module `ms_timer`:**
  - inputs `clear` and `run`;
  - 1 ms tick counter and ms counter;
  - `expired` output compared against a `limit` input.
  - It is reusable by the letter generators later.
- **Top FSM:** one sequential always block, with registered output decode.

## Test plan
- **Reset.** Apply `rst_n`=0 mid-run. Require `pin_out`=1, both starts 0, `busy`=0, `frame_cnt`=0 immediately, then held.
- **Single frame.** Parameters: `T1MS`=9, `LETTER_GAP_MS`=2, `FRAME_GAP_MS`=5. Generator models: done is a 1-cycle pulse 30 cycles after start. Apply a 1-cycle `enable` pulse. Require:
  - `s_start_sig` for 31 cycles, then 20 idle cycles;
  - then `o_start_sig`, 20 idle cycles, then `s_start_sig`;
  - `frame_done` pulse and `frame_cnt`=1;
  - IDLE with no FGAP.
- **Continuous.** Hold `enable`=1 with the same parameters. Require:
  - a 50-cycle FGAP between frames;
  - `frame_cnt` steps 1, 2, 3;
  - preload `frame_cnt`=255 and require a wrap to 0.
- **Spurious done.** Pulse `o_done_sig` during S1, and `s_done_sig` during GAP1. Require no state change and unchanged gap length.
- **`pin_out` mux.** Toggle `s_pin_out` during O and gaps, and toggle `o_pin_out` during S1. Require `pin_out` to follow only the active source, one cycle late, and stay 1 in gaps.
- **Zero gaps.** Set `LETTER_GAP_MS`=0 and `FRAME_GAP_MS`=0 with `enable`=1. Require S1→O→S2→S1 transitions on the cycle after each done.
